// File: rtl/sdram_phy_io.sv
// SDRAM pin-side PHY: registered command/data outputs, READ-driven capture scheduling, contention flag.
// Optional read-word counter output rd_words_o is enabled by defining SDRAM_PHY_RD_COUNT_EN.
module sdram_phy_io #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 13,
    parameter int BA_W        = 2,
    parameter int CAS_LATENCY = 2,
    parameter int CAPTURE_DLY = 0,
    parameter int BURST_LEN   = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ctrl_cs_i,
    input  logic                ctrl_ras_i,
    input  logic                ctrl_cas_i,
    input  logic                ctrl_we_i,
    input  logic                ctrl_cke_i,
    input  logic [ADDR_W-1:0]   ctrl_addr_i,
    input  logic [BA_W-1:0]     ctrl_ba_i,
    input  logic [DATA_W/8-1:0] ctrl_dqm_i,
    input  logic [DATA_W-1:0]   ctrl_dq_i,
    input  logic                ctrl_dq_oe_i,
    output logic                sdram_cs_o,
    output logic                sdram_ras_o,
    output logic                sdram_cas_o,
    output logic                sdram_we_o,
    output logic                sdram_cke_o,
    output logic [ADDR_W-1:0]   sdram_addr_o,
    output logic [BA_W-1:0]     sdram_ba_o,
    output logic [DATA_W/8-1:0] sdram_dqm_o,
    output logic [DATA_W-1:0]   sdram_dq_o,
    output logic                sdram_dq_oe_o,
    input  logic [DATA_W-1:0]   sdram_dq_i,
    output logic                rd_valid_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_busy_o,
    output logic                err_o,
    input  logic                err_clr_i
`ifdef SDRAM_PHY_RD_COUNT_EN
    ,
    output logic [31:0]         rd_words_o
`endif
);

    localparam int LAT = CAS_LATENCY + CAPTURE_DLY;
    localparam int L   = LAT + BURST_LEN + 1;
    // Bit k of the schedule matures k cycles after the cycle following the READ.
    localparam logic [L-1:0] RD_MASK = L'(((32'd1 << BURST_LEN) - 32'd1) << LAT);

    logic         w_rd_dec;
    logic         w_mature;
    logic [L-1:0] r_sched;

    assign w_rd_dec  = ~ctrl_cs_i & ctrl_ras_i & ~ctrl_cas_i & ctrl_we_i & ctrl_cke_i;
    assign w_mature  = r_sched[0];
    assign rd_busy_o = (|r_sched) | w_rd_dec;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sdram_cs_o    <= 1'b1;
            sdram_ras_o   <= 1'b1;
            sdram_cas_o   <= 1'b1;
            sdram_we_o    <= 1'b1;
            sdram_cke_o   <= 1'b0;
            sdram_addr_o  <= '0;
            sdram_ba_o    <= '0;
            sdram_dqm_o   <= '1;
            sdram_dq_o    <= '0;
            sdram_dq_oe_o <= 1'b0;
        end else begin
            sdram_cs_o    <= ctrl_cs_i;
            sdram_ras_o   <= ctrl_ras_i;
            sdram_cas_o   <= ctrl_cas_i;
            sdram_we_o    <= ctrl_we_i;
            sdram_cke_o   <= ctrl_cke_i;
            sdram_addr_o  <= ctrl_addr_i;
            sdram_ba_o    <= ctrl_ba_i;
            sdram_dqm_o   <= ctrl_dqm_i;
            sdram_dq_o    <= ctrl_dq_i;
            sdram_dq_oe_o <= ctrl_dq_oe_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sched    <= '0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            r_sched    <= (r_sched >> 1) | (w_rd_dec ? RD_MASK : {L{1'b0}});
            rd_valid_o <= w_mature;
            if (w_mature) begin
                rd_data_o <= sdram_dq_i;
            end
        end
    end

    // Set wins over a simultaneous clear so a fresh contention event is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (w_mature && sdram_dq_oe_o) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

`ifdef SDRAM_PHY_RD_COUNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_words_o <= '0;
        end else if (rd_valid_o) begin
            rd_words_o <= rd_words_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_phy_io.sv
// Directed bench for sdram_phy_io: three instances (CL2/BL1, CL2/BL4, CL3/CD2/BL1) share stimulus.
module tb_sdram_phy_io;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs, ras, cas, we, cke, oe, clr;
    logic [12:0] addr;
    logic [1:0]  ba, dqm;
    logic [15:0] dq, dq_in;

    logic        cs_o[3], ras_o[3], cas_o[3], we_o[3], cke_o[3], oe_o[3];
    logic [12:0] addr_o[3];
    logic [1:0]  ba_o[3], dqm_o[3];
    logic [15:0] dq_o[3], rd_data[3];
    logic        rd_valid[3], rd_busy[3], err[3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sdram_phy_io #(
            .DATA_W(16), .ADDR_W(13), .BA_W(2),
            .CAS_LATENCY(g == 2 ? 3 : 2),
            .CAPTURE_DLY(g == 2 ? 2 : 0),
            .BURST_LEN(g == 1 ? 4 : 1)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .ctrl_cs_i(cs), .ctrl_ras_i(ras), .ctrl_cas_i(cas), .ctrl_we_i(we),
            .ctrl_cke_i(cke), .ctrl_addr_i(addr), .ctrl_ba_i(ba), .ctrl_dqm_i(dqm),
            .ctrl_dq_i(dq), .ctrl_dq_oe_i(oe),
            .sdram_cs_o(cs_o[g]), .sdram_ras_o(ras_o[g]), .sdram_cas_o(cas_o[g]),
            .sdram_we_o(we_o[g]), .sdram_cke_o(cke_o[g]), .sdram_addr_o(addr_o[g]),
            .sdram_ba_o(ba_o[g]), .sdram_dqm_o(dqm_o[g]), .sdram_dq_o(dq_o[g]),
            .sdram_dq_oe_o(oe_o[g]), .sdram_dq_i(dq_in),
            .rd_valid_o(rd_valid[g]), .rd_data_o(rd_data[g]), .rd_busy_o(rd_busy[g]),
            .err_o(err[g]), .err_clr_i(clr)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rd);
        cs  = ~rd;
        ras = 1'b1;
        cas = ~rd;
        we  = 1'b1;
    endtask

    initial begin
        cs = 1; ras = 1; cas = 1; we = 1; cke = 0; oe = 0; clr = 0;
        addr = '0; ba = '0; dqm = '1; dq = '0; dq_in = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_cs", 32'(cs_o[0]), 32'd1);
        check("rst_ras", 32'(ras_o[0]), 32'd1);
        check("rst_cas", 32'(cas_o[0]), 32'd1);
        check("rst_we", 32'(we_o[0]), 32'd1);
        check("rst_cke", 32'(cke_o[0]), 32'd0);
        check("rst_addr", 32'(addr_o[0]), 32'd0);
        check("rst_dqm", 32'(dqm_o[0]), 32'd3);
        check("rst_oe", 32'(oe_o[0]), 32'd0);
        check("rst_valid", 32'(rd_valid[0]), 32'd0);
        check("rst_data", 32'(rd_data[0]), 32'd0);
        check("rst_busy", 32'(rd_busy[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        rst_n = 1;
        tick();
        tick();
        check("rel_cs", 32'(cs_o[0]), 32'd1);
        check("rel_dqm", 32'(dqm_o[0]), 32'd3);
        check("rel_valid", 32'(rd_valid[2]), 32'd0);

        // ACTIVE command passes through one cycle later
        cke = 1; cs = 0; ras = 0; cas = 1; we = 1;
        addr = 13'h1ABC; ba = 2'd2; dqm = 2'b01; dq = 16'h1234;
        #1;
        check("cmd_pre_cs", 32'(cs_o[0]), 32'd1);
        tick();
        issue(0); addr = '0; ba = '0; dqm = '0; dq = '0;
        #1;
        check("cmd_cs", 32'(cs_o[0]), 32'd0);
        check("cmd_ras", 32'(ras_o[0]), 32'd0);
        check("cmd_cas", 32'(cas_o[0]), 32'd1);
        check("cmd_cke", 32'(cke_o[0]), 32'd1);
        check("cmd_addr", 32'(addr_o[0]), 32'h1ABC);
        check("cmd_ba", 32'(ba_o[0]), 32'd2);
        check("cmd_dqm", 32'(dqm_o[0]), 32'd1);
        check("cmd_dq", 32'(dq_o[0]), 32'h1234);
        tick();
        check("cmd_nop_cs", 32'(cs_o[0]), 32'd1);

        // Single READ: CL2/BL1 word at +4, CL3/CD2 word at +7
        issue(1);
        #1;
        check("bl1_busy_dec", 32'(rd_busy[0]), 32'd1);
        tick();
        for (int i = 1; i <= 8; i++) begin
            issue(0);
            dq_in = (i == 3) ? 16'hA5C3 : 16'(16'h0100 + i);
            #1;
            check("bl1_valid", 32'(rd_valid[0]), 32'(i == 4));
            check("cd2_valid", 32'(rd_valid[2]), 32'(i == 7));
            if (i == 4 || i == 5) check("bl1_data", 32'(rd_data[0]), 32'hA5C3);
            if (i == 7) check("cd2_data", 32'(rd_data[2]), 32'h0106);
            tick();
        end

        // BL4 back-to-back READs four cycles apart
        for (int i = 0; i <= 12; i++) begin
            issue(i == 0 || i == 4);
            dq_in = 16'(16'hB000 + i);
            #1;
            check("bl4_busy", 32'(rd_busy[1]), 32'(i <= 10));
            check("bl4_valid", 32'(rd_valid[1]), 32'(i >= 4 && i <= 11));
            if (i >= 4 && i <= 11) check("bl4_data", 32'(rd_data[1]), 32'(16'hB000 + i - 1));
            tick();
        end

        // Write drive overlapping the capture window, then clear
        for (int i = 0; i <= 11; i++) begin
            issue(i == 0);
            oe = (i == 2);
            clr = (i == 10);
            dq_in = 16'hC0DE;
            #1;
            check("cont_err", 32'(err[0]), 32'(i >= 4 && i <= 10));
            if (i == 4) begin
                check("cont_valid", 32'(rd_valid[0]), 32'd1);
                check("cont_data", 32'(rd_data[0]), 32'hC0DE);
            end
            tick();
        end

        // Set and clear in the same cycle: set wins
        for (int i = 0; i <= 6; i++) begin
            issue(i == 0);
            oe = (i == 2);
            clr = (i == 3 || i == 5);
            #1;
            check("prio_err", 32'(err[0]), 32'(i == 4 || i == 5));
            tick();
        end
        oe = 0; clr = 0;

        // Reset pulse mid-flight discards pending captures
        for (int i = 0; i <= 10; i++) begin
            issue(i == 0);
            if (i == 1) begin
                #1;
                check("mid_busy_pre", 32'(rd_busy[2]), 32'd1);
            end
            if (i == 2) begin
                rst_n = 0;
                #2;
                rst_n = 1;
            end
            #1;
            if (i >= 2) begin
                check("mid_valid0", 32'(rd_valid[0]), 32'd0);
                check("mid_valid2", 32'(rd_valid[2]), 32'd0);
                check("mid_busy", 32'(rd_busy[2]), 32'd0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
